seq_addsub_unit: RTL
====================

# seq_addsub_unit

Parametrised multi-cycle add/subtract unit, successor to the 64-bit combinational ripple-carry difference block. It processes a WIDTH-bit operand pair CHUNK bits per clock through one shared CHUNK-bit ripple-carry slice. This trades latency for area and a short critical path. It sits behind a start/done handshake so a controller or ALU datapath can issue back-to-back operations.

## Interface
- WIDTH, 64: operand/result width; must be a multiple of CHUNK.
- CHUNK, 16: bits processed per cycle; must be ≥ 1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset; one clock, all state reset by it.
- start  input  1  request; sampled only when the unit is idle or in the done state.
- mode  input  1  0 = in1 + in2, 1 = in1 − in2; latched with start.
- in1  input  WIDTH  operand A; latched with start.
- in2  input  WIDTH  operand B; latched with start.
- busy  output  1  high while the RUN state is active.
- done  output  1  one-cycle pulse: result and flags are valid.
- sum  output  WIDTH  result; held until the next accepted start.
- c_out  output  1  carry out of the MSB; in subtract mode 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN: on start=1.
  - Latch in1 and mode.
  - Latch in2, inverted if mode=1.
  - Set carry to mode (the +1 of the two's complement).
  - Clear the chunk index and the result register.
- RUN, each cycle:
  - Feed the slice with chunk[idx] of A, chunk[idx] of B', and the carry register.
  - Write the slice sum into result bits [idx*CHUNK +: CHUNK].
  - Store the slice carry out; idx increments.
- RUN → DONE: after N = WIDTH/CHUNK RUN cycles (idx wraps from N−1).
  - c_out = final carry.
  - ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]).
- DONE → RUN: if start=1 (back-to-back issue).
- DONE → IDLE: otherwise.
- start during RUN is ignored; the operation in flight is not disturbed, and the operand inputs are don't-care.
- Arithmetic is modulo 2^WIDTH: no saturation, the result wraps.
- Reset state, at any time including mid-operation:
  - state = IDLE, idx = 0, carry = 0.
  - sum = 0, c_out = 0, ovf = 0, busy = 0, done = 0.
  - Any partial result is discarded.

## Timing
- Edge 0: start accepted. busy = 1 from edge 0 through edge N.
- Edge N: RUN completes and the FSM enters DONE.
- done = 1 for exactly the cycle after edge N. Latency from start edge to done = N+1 edges (N = 4 at default parameters).
- sum, c_out and ovf are registered:
  - They are stable and valid whenever done = 1.
  - They are held until the edge that accepts the next start, when sum clears.
- Issue rate:
  - Back-to-back: start held high in DONE gives one result per N+1 cycles.
  - Via IDLE: one result per N+2 cycles.
- CHUNK = WIDTH gives a single-cycle RUN with the same handshake.

## Structure
- Shared package seq_addsub_pkg:
  - State encoding localparams S_IDLE, S_RUN, S_DONE.
  - Mode constants MODE_ADD = 0, MODE_SUB = 1.
- Sub-module rca_chunk: combinational CHUNK-bit ripple-carry adder (a, b, c_in → s, c_out), built from full-adder cells. Exactly one instance.
- Top level holds the FSM, the idx counter of clog2(N) bits (min 1), the operand/carry/result registers and the flag logic.

## Test plan
- Subtract, defaults: 98345672198765 − 12765438912345 → sum = 85580233286420, c_out = 1, ovf = 0, done at edge 5.
- Negative subtract: 12345432198765 − 98765678912345 → sum = 18446657653462838036, c_out = 0 (borrow).
- Add without carry: 18446744073709000005 + 55161 → sum = 18446744073709055166, c_out = 0.
- Add with wrap-around: 18446744073709000006 + 551610 → sum = 0, c_out = 1, ovf = 0.
- Back-to-back with a mid-run start:
  - Start held high in DONE → the second result has done exactly 5 cycles after the first.
  - Start pulsed during RUN → ignored, the first result is unchanged.
- Reset and parameter sweep:
  - Deassert rst_n at RUN cycle 2 → all outputs 0 immediately and state IDLE; the next start completes normally.
  - Repeat the random add/sub compare against a reference model at CHUNK = 1, 8, 64.

Source files
------------

// File: rtl/seq_addsub_pkg.sv
// Shared definitions for the sequential add/subtract unit: FSM encoding,
// operation mode constants and a small width helper for the chunk index.
package seq_addsub_pkg;

  // FSM state encoding
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Operation select values on the mode input
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Width of a counter that must hold 0..n-1, never less than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_addsub_unit_rca_chunk.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
// This is the only arithmetic in the unit; it is reused every RUN cycle.
module rca_chunk #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] s,
  output logic             c_out
);

  // carry[i] is the carry into bit i; carry[CHUNK] leaves the slice
  logic [CHUNK:0] carry;

  assign carry[0] = c_in;

  // One full-adder cell per bit, chained through the carry vector
  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
      logic p;
      assign p             = a[gi] ^ b[gi];
      assign s[gi]         = p ^ carry[gi];
      assign carry[gi + 1] = (a[gi] & b[gi]) | (p & carry[gi]);
    end
  endgenerate

  assign c_out = carry[CHUNK];

endmodule

// File: rtl/seq_addsub_unit.sv
// Multi-cycle WIDTH-bit add/subtract unit. Operands are processed CHUNK bits
// per clock through a single shared ripple-carry slice, behind a start/done
// handshake. Subtraction is done as A + ~B + 1 with the +1 injected as the
// initial carry, so c_out = 1 means "no borrow" in subtract mode.
module seq_addsub_unit
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = idx_width(N);
  localparam int MSB   = WIDTH - 1;

  // Elaboration-time parameter sanity
  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("seq_addsub_unit: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  state_t             state_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;      // already inverted for subtraction
  logic               carry_reg;  // starts at mode: the two's-complement +1
  logic [WIDTH-1:0]   result_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               c_out_reg;
  logic               ovf_reg;

  logic [CHUNK-1:0]   slice_a;
  logic [CHUNK-1:0]   slice_b;
  logic [CHUNK-1:0]   slice_s;
  logic               slice_c;
  logic               last_chunk;

  // Select the current chunk of both operands for the shared slice
  always_comb begin
    slice_a    = a_reg[int'(idx_reg) * CHUNK +: CHUNK];
    slice_b    = b_reg[int'(idx_reg) * CHUNK +: CHUNK];
    last_chunk = (idx_reg == IDX_W'(N - 1));
  end

  rca_chunk #(
    .CHUNK (CHUNK)
  ) u_rca_chunk (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry_reg),
    .s     (slice_s),
    .c_out (slice_c)
  );

  // FSM, operand/result registers and registered status/flag outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      idx_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      carry_reg  <= 1'b0;
      result_reg <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      c_out_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_reg      <= in1;
            b_reg      <= (mode == MODE_SUB) ? ~in2 : in2;
            carry_reg  <= mode;
            idx_reg    <= '0;
            result_reg <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= S_RUN;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end
        end
        S_RUN: begin
          // start is deliberately ignored here; the operation runs to completion
          result_reg[int'(idx_reg) * CHUNK +: CHUNK] <= slice_s;
          carry_reg <= slice_c;
          if (last_chunk) begin
            idx_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            c_out_reg <= slice_c;
            // Signed overflow: operands agree in sign but the result does not.
            // The result MSB comes straight from the slice in this last cycle.
            ovf_reg   <= (a_reg[MSB] == b_reg[MSB]) && (slice_s[CHUNK-1] != a_reg[MSB]);
            state_reg <= S_DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_reg;
  assign done  = done_reg;
  assign sum   = result_reg;
  assign c_out = c_out_reg;
  assign ovf   = ovf_reg;

endmodule
